// File: rtl/ps2_debouncer.sv
// Two-channel PS/2 input conditioner: each pad is synchronised into clk and
// only passed to its output after holding a new level for COUNT_MAX+1 edges.
module ps2_debouncer #(
  parameter int   COUNT_MAX  = 19,
  parameter int   COUNT_W    = 5,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic I0,
  input  logic I1,
  output logic O0,
  output logic O1
);

  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(COUNT_MAX);

  logic [1:0] pad;
  logic [1:0] level;

  assign pad = {I1, I0};
  assign O0  = level[0];
  assign O1  = level[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic               sync1;
    logic               sync2;
    logic               out_q;
    logic [COUNT_W-1:0] cnt;

    // cnt counts consecutive edges on which sync2 disagrees with the output;
    // any agreeing edge restarts the run from zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= IDLE_LEVEL;
        sync2 <= IDLE_LEVEL;
        out_q <= IDLE_LEVEL;
        cnt   <= '0;
      end else begin
        sync1 <= pad[ch];
        sync2 <= sync1;
        if (sync2 == out_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          out_q <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + COUNT_W'(1);
        end
      end
    end

    assign level[ch] = out_q;

    cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_LAST);
  end

endmodule

// File: tb/tb_ps2_debouncer.sv
// Bench for ps2_debouncer: fixed vector table, hand-written corner sequences
// and random run-length stimulus against a sliding-window reference model.
module tb_ps2_debouncer;

  localparam int CM = 19;

  logic clk;
  logic clk_en;
  logic rst_n;
  logic i0;
  logic i1;
  logic o0;
  logic o1;

  int tests;
  int fails;

  ps2_debouncer #(.COUNT_MAX(CM), .COUNT_W(5), .IDLE_LEVEL(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .I0   (i0),
    .I1   (i1),
    .O0   (o0),
    .O1   (o1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each output flips to the opposite level once the last CM+1 synchronised
  // samples (input delayed by two edges) all carry that opposite level.
  logic [1:0]  in_q[$];
  logic [63:0] hist[2];
  int          since_rst;
  logic [1:0]  mo;

  task automatic model_reset();
    in_q      = '{2'b11, 2'b11};
    hist[0]   = '0;
    hist[1]   = '0;
    since_rst = 0;
    mo        = 2'b11;
  endtask

  task automatic model_edge(input logic [1:0] x);
    logic [1:0]  s2;
    logic [63:0] mask;
    in_q.push_back(x);
    s2 = in_q.pop_front();
    since_rst++;
    mask = (64'd1 << (CM + 1)) - 64'd1;
    for (int c = 0; c < 2; c++) begin
      hist[c] = {hist[c][62:0], s2[c]};
      if (since_rst >= CM + 1 && (hist[c] & mask) == (mo[c] ? 64'd0 : mask))
        mo[c] = ~mo[c];
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic a, input logic b);
    i0 = a;
    i1 = b;
    @(posedge clk);
    #1;
    model_edge({b, a});
    check("model", {o1, o0}, mo);
  endtask

  // Called at posedge+1: reset asserts mid-cycle, spans one edge, releases.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", {o1, o0}, 2'b11);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_hold", {o1, o0}, 2'b11);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic a;
    logic b;
    int   n;
    logic e0;
    logic e1;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int rem0;
    int rem1;
    logic lv0;
    logic lv1;
    logic v;

    tests  = 0;
    fails  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    i0     = 1'b0;
    i1     = 1'b0;

    // hold, I0 fall/rise latency, 19/20-cycle pulses, I1 chatter burst
    tbl.push_back('{1'b1, 1'b1, 50, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 21, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1,  1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 21, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1,  1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 19, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 25, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 20, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1,  1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1,  1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 19, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1,  1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 10, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1,  1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 20, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0,  1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 10, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 22, 1'b1, 1'b1});

    // reset with clock stopped and inputs low
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_noclk", {o1, o0}, 2'b11);
    model_reset();
    i0 = 1'b1;
    i1 = 1'b1;
    #10;
    check("reset_noclk_hold", {o1, o0}, 2'b11);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      for (int j = 0; j < tbl[k].n; j++) step(tbl[k].a, tbl[k].b);
      check($sformatf("vec%0d", k), {o1, o0}, {tbl[k].e1, tbl[k].e0});
    end

    // I1 toggles every 3 cycles while I0 steps low
    for (int k = 1; k <= 30; k++) begin
      v = (((k - 1) / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step(1'b0, v);
      check("t5_o1", {1'b0, o1}, 2'b01);
      check("t5_o0", {1'b0, o0}, (k >= 22) ? 2'b00 : 2'b01);
    end
    for (int k = 0; k < 25; k++) step(1'b1, 1'b1);
    check("t5_restore", {o1, o0}, 2'b11);

    // reset mid-count discards the partial run
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1);
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, 1'b1);
      if (k == 21) check("t6_edge21", {o1, o0}, 2'b11);
      if (k == 22) check("t6_edge22", {o1, o0}, 2'b10);
    end
    for (int k = 0; k < 25; k++) step(1'b1, 1'b1);

    // random run-length stimulus, occasional resets
    rem0 = 0;
    rem1 = 0;
    lv0  = 1'b1;
    lv1  = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (rem0 == 0) begin
        lv0  = 1'($urandom_range(0, 1));
        rem0 = $urandom_range(1, 30);
      end
      if (rem1 == 0) begin
        lv1  = 1'($urandom_range(0, 1));
        rem1 = $urandom_range(1, 30);
      end
      step(lv0, lv1);
      rem0--;
      rem1--;
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
